// File: rtl/fetch_queue_if.sv
// Core/memory-side signal bundle of the instruction prefetch queue.
// The master modport is the queue itself; the slave side is the core plus memory.
interface fetch_queue_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
);
    logic                    o_mem_req;
    logic [ADDR_W-1:0]       o_mem_addr;
    logic                    i_mem_ack;
    logic                    i_mem_rvalid;
    logic [DATA_W-1:0]       i_mem_rdata;
    logic                    o_inst_valid;
    logic [DATA_W-1:0]       o_inst;
    logic [ADDR_W-1:0]       o_inst_pc;
    logic                    i_inst_ready;
    logic                    i_redirect;
    logic [ADDR_W-1:0]       i_redirect_pc;
    logic [$clog2(DEPTH):0]  o_count;

    modport master (
        output o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_count,
        input  i_mem_ack, i_mem_rvalid, i_mem_rdata, i_inst_ready, i_redirect, i_redirect_pc
    );

    modport slave (
        input  o_mem_req, o_mem_addr, o_inst_valid, o_inst, o_inst_pc, o_count,
        output i_mem_ack, i_mem_rvalid, i_mem_rdata, i_inst_ready, i_redirect, i_redirect_pc
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a registered head output; flush beats push and pop.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && !full;

    always_ff @(posedge i_clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdata  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
            // The head register must track whichever entry becomes the head next cycle.
            if (do_push && (empty || (do_pop && count == (PW+1)'(1))))
                rdata <= wdata;
            else if (do_pop && count > (PW+1)'(1))
                rdata <= mem[rd_ptr + 1'b1];
        end
    end
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch unit: credit-limited fetch issue, in-order response buffering,
// and redirect flush with discard of responses still in flight.
module fetch_queue #(
    parameter int              ADDR_W   = 16,
    parameter int              DATA_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic           i_clk,
    input logic           i_rst_n,
    fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        tail_pc;
    logic [CW-1:0]            pending;
    logic [CW-1:0]            pending_next;
    logic [CW-1:0]            discard;
    logic [CW-1:0]            count;
    logic [CW:0]              in_use;
    logic                     issue;
    logic                     drop;
    logic                     push;
    logic                     pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [DATA_W+ADDR_W-1:0] head;

    assign in_use           = {1'b0, count} + {1'b0, pending};
    assign bus.o_mem_req    = i_rst_n && (in_use < (CW+1)'(DEPTH)) && !bus.i_redirect;
    assign bus.o_mem_addr   = fetch_pc;
    assign issue            = bus.o_mem_req && bus.i_mem_ack;
    assign drop             = bus.i_mem_rvalid && (discard != '0);
    assign push             = bus.i_mem_rvalid && !drop && !bus.i_redirect;
    assign pop              = bus.i_inst_ready && !bus.i_redirect;
    assign pending_next     = pending + CW'(issue) - CW'(bus.i_mem_rvalid);

    assign bus.o_inst_valid = !fifo_empty;
    assign bus.o_inst       = head[DATA_W+ADDR_W-1:ADDR_W];
    assign bus.o_inst_pc    = head[ADDR_W-1:0];
    assign bus.o_count      = count;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + ADDR_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (bus.i_redirect),
        .wdata   ({bus.i_mem_rdata, tail_pc}),
        .rdata   (head),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            fetch_pc <= RESET_PC;
            tail_pc  <= RESET_PC;
            pending  <= '0;
            discard  <= '0;
        end else begin
            pending <= pending_next;
            if (bus.i_redirect) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                discard  <= pending_next;
                fetch_pc <= bus.i_redirect_pc;
                tail_pc  <= bus.i_redirect_pc;
            end else begin
                if (drop)  discard  <= discard - 1'b1;
                if (issue) fetch_pc <= fetch_pc + 1'b1;
                if (push)  tail_pc  <= tail_pc + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n) assert (!(bus.i_mem_rvalid && fifo_full));
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: pipelined memory model with configurable latency,
// expected-instruction scoreboard, steady-state vector table and redirect/reset sequences.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_queue_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(4)) bus ();

    fetch_queue #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct { logic [15:0] addr; int due; } mreq_t;
    typedef struct { logic [15:0] pc; logic [15:0] data; } exp_t;
    typedef struct {
        int lat; bit ready; int cycles;
        int exp_count; bit exp_req; bit exp_valid; int exp_acks;
    } vec_t;

    mreq_t       memq[$];
    exp_t        exp_q[$];
    logic [15:0] ack_log[$];
    logic [15:0] exp_fetch_pc;
    logic [15:0] prev_pc;
    vec_t        tbl[5];
    int          lat;
    int          cycle;
    int          n_acks;
    int          n_tests;
    int          n_fail;

    function automatic logic [15:0] img(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A5A;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    task automatic check_ack(input int idx, input logic [15:0] exp);
        check($sformatf("ack_addr[%0d]", idx),
              (idx < ack_log.size()) ? {16'h0, ack_log[idx]} : 32'hDEAD_BEEF, {16'h0, exp});
    endtask

    // One clock cycle: memory drives its response, handshakes are observed, scoreboard updated.
    task automatic step();
        exp_t e;
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = '0;
        if (rst_n && memq.size() > 0 && memq[0].due <= cycle) begin
            bus.i_mem_rvalid = 1'b1;
            bus.i_mem_rdata  = img(memq[0].addr);
        end
        #1;
        if (!rst_n) begin
            memq.delete();
            exp_q.delete();
            exp_fetch_pc = 16'h0000;
        end else begin
            if (bus.i_mem_rvalid) void'(memq.pop_front());
            if (!bus.i_redirect && bus.o_inst_valid && bus.i_inst_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_pop_pc", {16'h0, bus.o_inst_pc}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", {16'h0, bus.o_inst_pc}, {16'h0, e.pc});
                    check("sb_inst", {16'h0, bus.o_inst}, {16'h0, e.data});
                end
            end
            if (bus.o_mem_req && bus.i_mem_ack) begin
                check("mem_addr", {16'h0, bus.o_mem_addr}, {16'h0, exp_fetch_pc});
                memq.push_back('{bus.o_mem_addr, cycle + lat});
                ack_log.push_back(bus.o_mem_addr);
                exp_q.push_back('{exp_fetch_pc, img(exp_fetch_pc)});
                exp_fetch_pc = exp_fetch_pc + 16'h1;
                n_acks++;
            end
            if (bus.i_redirect) begin
                exp_q.delete();
                exp_fetch_pc = bus.i_redirect_pc;
            end
        end
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        check("rst_count", {29'h0, bus.o_count}, 32'd0);
        check("rst_req", {31'h0, bus.o_mem_req}, 32'd0);
        check("rst_valid", {31'h0, bus.o_inst_valid}, 32'd0);
        check("rst_inst", {16'h0, bus.o_inst}, 32'd0);
        check("rst_inst_pc", {16'h0, bus.o_inst_pc}, 32'd0);
        rst_n = 1'b1;
        ack_log.delete();
        n_acks = 0;
    endtask

    task automatic wait_valid(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && !bus.o_inst_valid; i++) step();
        check({name, "_valid"}, {31'h0, bus.o_inst_valid}, 32'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cycle   = 0;
        n_acks  = 0;
        lat     = 1;
        exp_fetch_pc      = 16'h0000;
        rst_n             = 1'b0;
        bus.i_mem_ack     = 1'b1;
        bus.i_mem_rvalid  = 1'b0;
        bus.i_mem_rdata   = '0;
        bus.i_inst_ready  = 1'b0;
        bus.i_redirect    = 1'b0;
        bus.i_redirect_pc = '0;
        @(negedge clk);

        // steady-state vectors: {lat, ready, cycles, count, req, valid, accepted requests}
        tbl[0] = '{1, 1'b0, 12, 4, 1'b0, 1'b1, 4};
        tbl[1] = '{2, 1'b0, 12, 4, 1'b0, 1'b1, 4};
        tbl[2] = '{3, 1'b0, 14, 4, 1'b0, 1'b1, 4};
        tbl[3] = '{5, 1'b0, 16, 4, 1'b0, 1'b1, 4};
        tbl[4] = '{1, 1'b1, 20, 1, 1'b1, 1'b1, 20};
        for (int k = 0; k < 5; k++) begin
            lat = tbl[k].lat;
            bus.i_inst_ready = tbl[k].ready;
            do_reset();
            repeat (tbl[k].cycles) step();
            check($sformatf("vec%0d_count", k), {29'h0, bus.o_count}, tbl[k].exp_count);
            check($sformatf("vec%0d_req", k), {31'h0, bus.o_mem_req}, {31'h0, tbl[k].exp_req});
            check($sformatf("vec%0d_valid", k), {31'h0, bus.o_inst_valid}, {31'h0, tbl[k].exp_valid});
            check($sformatf("vec%0d_acks", k), n_acks, tbl[k].exp_acks);
        end

        // streaming with 1-cycle memory and a core that is always ready
        lat = 1;
        bus.i_inst_ready = 1'b1;
        do_reset();
        step();
        step();
        check("stream_first_valid", {31'h0, bus.o_inst_valid}, 32'd1);
        check("stream_first_pc", {16'h0, bus.o_inst_pc}, 32'h0000);
        for (int i = 0; i < 6; i++) begin
            prev_pc = bus.o_inst_pc;
            step();
            check("stream_valid", {31'h0, bus.o_inst_valid}, 32'd1);
            check("stream_pc_inc", {16'h0, bus.o_inst_pc}, {16'h0, prev_pc + 16'h1});
        end
        for (int i = 0; i < 4; i++) check_ack(i, 16'(i));

        // stalled core: fill, then one pop buys exactly one new request
        bus.i_inst_ready = 1'b0;
        do_reset();
        repeat (10) step();
        check("stall_acks", n_acks, 4);
        check("stall_count", {29'h0, bus.o_count}, 32'd4);
        check("stall_req", {31'h0, bus.o_mem_req}, 32'd0);
        bus.i_inst_ready = 1'b1;
        step();
        bus.i_inst_ready = 1'b0;
        n_acks = 0;
        repeat (6) step();
        check("stall_refill_acks", n_acks, 1);
        check("stall_refill_count", {29'h0, bus.o_count}, 32'd4);
        check("stall_head_pc", {16'h0, bus.o_inst_pc}, 32'h0001);

        // 3-cycle memory, 3 in flight, redirect to 0x0040
        lat = 3;
        bus.i_inst_ready = 1'b0;
        do_reset();
        repeat (3) step();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0040;
        ack_log.delete();
        step();
        bus.i_redirect = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stale_count", {29'h0, bus.o_count}, 32'd0);
            check("stale_valid", {31'h0, bus.o_inst_valid}, 32'd0);
            step();
        end
        wait_valid("redir40", 10);
        check("redir40_pc", {16'h0, bus.o_inst_pc}, 32'h0040);
        check("redir40_inst", {16'h0, bus.o_inst}, {16'h0, img(16'h0040)});
        check_ack(0, 16'h0040);

        // redirect in a cycle with ack, response and pop all active
        lat = 1;
        bus.i_inst_ready = 1'b1;
        do_reset();
        repeat (5) step();
        check("busy_valid", {31'h0, bus.o_inst_valid}, 32'd1);
        check("busy_rsp_due", memq.size(), 1);
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'h0100;
        step();
        bus.i_redirect = 1'b0;
        check("busy_flush_count", {29'h0, bus.o_count}, 32'd0);
        check("busy_flush_valid", {31'h0, bus.o_inst_valid}, 32'd0);
        wait_valid("redir100", 6);
        check("redir100_pc", {16'h0, bus.o_inst_pc}, 32'h0100);
        repeat (4) step();

        // redirect near the top of the address space
        do_reset();
        repeat (2) step();
        bus.i_redirect    = 1'b1;
        bus.i_redirect_pc = 16'hFFFE;
        step();
        bus.i_redirect = 1'b0;
        ack_log.delete();
        repeat (2) step();
        check("wrap_head_pc", {16'h0, bus.o_inst_pc}, 32'hFFFE);
        repeat (6) step();
        check_ack(0, 16'hFFFE);
        check_ack(1, 16'hFFFF);
        check_ack(2, 16'h0000);
        check_ack(3, 16'h0001);

        // reset with 2 buffered and 2 pending
        lat = 3;
        bus.i_inst_ready = 1'b0;
        do_reset();
        repeat (5) step();
        check("prerst_count", {29'h0, bus.o_count}, 32'd2);
        check("prerst_pending", memq.size(), 2);
        rst_n = 1'b0;
        step();
        check("midrst_count", {29'h0, bus.o_count}, 32'd0);
        check("midrst_req", {31'h0, bus.o_mem_req}, 32'd0);
        check("midrst_valid", {31'h0, bus.o_inst_valid}, 32'd0);
        rst_n = 1'b1;
        ack_log.delete();
        step();
        check_ack(0, 16'h0000);
        repeat (8) step();
        check("postrst_count", {29'h0, bus.o_count}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cycle);
        $fatal(1);
    end
endmodule
